// File: rtl/tone_detector.sv
// Tone detector: times the gap between rising midpoint crossings of the 4-bit
// sample stream and locks onto DO/RE/MI/SOL after two matching periods.
module tone_detector #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int MID     = 8,
    parameter int CW      = 20,
    parameter int TIMEOUT = 2 * CLK_HZ / 523
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    sample,
    output logic [3:0]    note,
    output logic          note_valid,
    output logic [CW-1:0] period,
    output logic          period_strobe
);
    localparam logic [3:0]    MID4  = 4'(MID);
    localparam logic [CW-1:0] P_DO  = CW'(CLK_HZ / 523);
    localparam logic [CW-1:0] P_RE  = CW'(CLK_HZ / 587);
    localparam logic [CW-1:0] P_MI  = CW'(CLK_HZ / 659);
    localparam logic [CW-1:0] P_SOL = CW'(CLK_HZ / 784);
    localparam logic [CW-1:0] TO_M1 = CW'(TIMEOUT - 1);
    localparam logic [3:0]    N_DO  = 4'b1000;
    localparam logic [3:0]    N_RE  = 4'b0100;
    localparam logic [3:0]    N_MI  = 4'b0010;
    localparam logic [3:0]    N_SOL = 4'b0001;

    typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_LOCKED} state_t;

    state_t        r_state;
    logic [3:0]    r_s1, r_s2, r_filt, r_filt_prev;
    logic          r_xing;
    logic [CW-1:0] r_cnt, r_period;
    logic [3:0]    r_match, r_cand, r_note;
    logic          r_valid, r_pstb;
    logic [3:0]    w_match;
    logic          w_timeout;

    // |p - pk| <= pk/32, evaluated one bit wider so nothing wraps
    function automatic logic in_win(input logic [CW-1:0] p, input logic [CW-1:0] pk);
        logic [CW:0] w_hi, w_lo;
        w_hi = {1'b0, pk} + {1'b0, pk >> 5};
        w_lo = {1'b0, p} + {1'b0, pk >> 5};
        return ({1'b0, p} <= w_hi) && (w_lo >= {1'b0, pk});
    endfunction

    always_comb begin
        w_match = 4'b0000;
        if (in_win(r_cnt, P_DO))       w_match = N_DO;
        else if (in_win(r_cnt, P_RE))  w_match = N_RE;
        else if (in_win(r_cnt, P_MI))  w_match = N_MI;
        else if (in_win(r_cnt, P_SOL)) w_match = N_SOL;
    end

    // Fires on the edge where cnt would become TIMEOUT, so silence drops the
    // note in the same cycle cnt shows TIMEOUT; a coincident crossing wins.
    assign w_timeout = !r_xing && (r_cnt >= TO_M1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1        <= '0;
            r_s2        <= '0;
            r_filt      <= '0;
            r_filt_prev <= '0;
            r_xing      <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_s1        <= sample;
            r_s2        <= r_s1;
            if (r_s1 == r_s2) r_filt <= r_s2;
            r_filt_prev <= r_filt;
            r_xing      <= (r_filt_prev < MID4) && (r_filt >= MID4);
            if (r_xing)            r_cnt <= CW'(1);
            else if (r_cnt != '1)  r_cnt <= r_cnt + 1'b1;
        end
    end

    // Crossings latch period and match; the classification acts a cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_period <= '0;
            r_pstb   <= 1'b0;
            r_match  <= '0;
            r_cand   <= '0;
            r_note   <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_pstb <= 1'b0;
            if (r_xing) begin
                if (r_state == S_IDLE) begin
                    r_state <= S_MEASURE;
                end else begin
                    r_period <= r_cnt;
                    r_pstb   <= 1'b1;
                    r_match  <= w_match;
                end
            end else if (w_timeout) begin
                r_state <= S_IDLE;
                r_cand  <= '0;
                r_note  <= '0;
                r_valid <= 1'b0;
            end else if (r_pstb) begin
                case (r_state)
                    S_MEASURE: begin
                        if (r_match == 4'b0000) begin
                            r_cand <= '0;
                        end else if (r_match == r_cand) begin
                            r_state <= S_LOCKED;
                            r_note  <= r_cand;
                            r_valid <= 1'b1;
                        end else begin
                            r_cand <= r_match;
                        end
                    end
                    S_LOCKED: begin
                        if (r_match != r_note) begin
                            r_state <= S_MEASURE;
                            r_cand  <= r_match;
                            r_note  <= '0;
                            r_valid <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign note          = r_note;
    assign note_valid    = r_valid;
    assign period        = r_period;
    assign period_strobe = r_pstb;
endmodule

// File: tb/tb_tone_detector.sv
// Bench for tone_detector: boundary table, timed corner sequences and random
// waveforms, all compared every cycle against a crossing-level reference model.
module tb_tone_detector;
    localparam int CW  = 20;
    localparam int TMO = 382;

    typedef struct {
        int         per;
        logic [3:0] note;
        logic       valid;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    sample = 4'd0;
    logic [3:0]    note;
    logic          note_valid;
    logic [CW-1:0] period;
    logic          period_strobe;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    vec_t tbl[17];
    int plist[14] = '{127, 128, 150, 151, 170, 171, 191, 192, 180, 60, 381, 382, 400, 130};

    tone_detector #(.CLK_HZ(100_000)) dut (
        .clk(clk), .rst_n(rst_n), .sample(sample), .note(note),
        .note_valid(note_valid), .period(period), .period_strobe(period_strobe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    logic [3:0] ring [4];
    int         m_rel = 1;
    logic [3:0] m_filt = 4'd0;
    int         xq[$];
    bit         m_run = 1'b0;
    int         m_last = 0;
    logic [3:0] m_prev = 4'd0;
    logic [3:0] e_note = 4'd0;
    int         e_period = 0;
    bit         e_stb = 1'b0;
    logic [3:0] pend_note = 4'd0;
    int         pend_at = -1;

    function automatic logic [3:0] classify(input int p);
        if (p >= 186 && p <= 196) return 4'b1000;
        if (p >= 165 && p <= 175) return 4'b0100;
        if (p >= 147 && p <= 155) return 4'b0010;
        if (p >= 124 && p <= 130) return 4'b0001;
        return 4'b0000;
    endfunction

    function automatic logic [3:0] veff(input int i);
        if (i < m_rel) return 4'd0;
        return ring[i % 4];
    endfunction

    always @(negedge clk) begin : model
        logic [3:0] a, b, nf, c;
        ring[cyc % 4] = sample;
        if (!rst_n) begin
            m_rel = cyc + 1; m_filt = 4'd0; xq.delete(); m_run = 1'b0; m_prev = 4'd0;
            e_note = 4'd0; e_period = 0; e_stb = 1'b0; pend_at = -1;
        end else begin
            a  = veff(cyc - 2);
            b  = veff(cyc - 3);
            nf = (a == b) ? b : m_filt;
            if (m_filt < 4'd8 && nf >= 4'd8) xq.push_back(cyc + 2);
            m_filt = nf;
            e_stb  = 1'b0;
            if (pend_at == cyc) e_note = pend_note;
            if (xq.size() > 0 && xq[0] == cyc) begin
                void'(xq.pop_front());
                if (m_run) begin
                    e_period  = cyc - m_last;
                    e_stb     = 1'b1;
                    c         = classify(e_period);
                    pend_note = (c != 4'd0 && c == m_prev) ? c : 4'd0;
                    pend_at   = cyc + 1;
                    m_prev    = c;
                end else begin
                    m_run  = 1'b1;
                    m_prev = 4'd0;
                end
                m_last = cyc;
            end else if (m_run && cyc - m_last >= TMO - 1) begin
                m_run = 1'b0; e_note = 4'd0; pend_at = -1;
            end
        end
        checks++;
        if ({note, note_valid, period, period_strobe} !==
            {e_note, (e_note != 4'd0), e_period[CW-1:0], e_stb}) begin
            errors++;
            $display("FAIL model cyc=%0d got note=%b valid=%b period=%0d strobe=%b, expected note=%b valid=%b period=%0d strobe=%b",
                     cyc, note, note_valid, period, period_strobe,
                     e_note, (e_note != 4'd0), e_period, e_stb);
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic drive(input logic [3:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1 sample = v;
        end
    endtask

    task automatic wave(input int per, input int n, input logic [3:0] hi, input logic [3:0] lo);
        for (int k = 0; k < n; k++) begin
            drive(hi, per / 2);
            drive(lo, per - per / 2);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        sample = 4'd0;
        drive(4'd0, 3);
        rst_n = 1'b1;
        drive(4'd0, 5);
    endtask

    task automatic at(input int t);
        if (cyc > t) begin
            checks++; errors++;
            $display("FAIL schedule: cyc %0d already past %0d", cyc, t);
        end else begin
            do @(negedge clk); while (cyc < t);
        end
    endtask

    initial begin
        #900_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        int t0, nstb, per, n;
        logic [3:0] hi, lo, v;

        tbl[0]  = '{192, 4'b1000, 1'b1};  tbl[1]  = '{186, 4'b1000, 1'b1};
        tbl[2]  = '{196, 4'b1000, 1'b1};  tbl[3]  = '{185, 4'b0000, 1'b0};
        tbl[4]  = '{197, 4'b0000, 1'b0};  tbl[5]  = '{170, 4'b0100, 1'b1};
        tbl[6]  = '{165, 4'b0100, 1'b1};  tbl[7]  = '{175, 4'b0100, 1'b1};
        tbl[8]  = '{164, 4'b0000, 1'b0};  tbl[9]  = '{151, 4'b0010, 1'b1};
        tbl[10] = '{147, 4'b0010, 1'b1};  tbl[11] = '{155, 4'b0010, 1'b1};
        tbl[12] = '{128, 4'b0001, 1'b1};  tbl[13] = '{124, 4'b0001, 1'b1};
        tbl[14] = '{130, 4'b0001, 1'b1};  tbl[15] = '{131, 4'b0000, 1'b0};
        tbl[16] = '{180, 4'b0000, 1'b0};

        // reset held with a toggling input
        for (int i = 0; i < 10; i++) drive((i % 2 == 0) ? 4'd15 : 4'd0, 1);
        @(negedge clk);
        chk("reset note", int'(note), 0);
        chk("reset valid", int'(note_valid), 0);
        chk("reset period", int'(period), 0);
        chk("reset strobe", int'(period_strobe), 0);
        @(posedge clk); #1 rst_n = 1'b1; sample = 4'd0;
        drive(4'd0, 50);
        chk("idle after reset valid", int'(note_valid), 0);

        // boundary table: 4 crossings of a clean square wave each
        foreach (tbl[i]) begin
            do_reset();
            wave(tbl[i].per, 4, 4'd15, 4'd0);
            chk($sformatf("tbl%0d note", i), int'(note), int'(tbl[i].note));
            chk($sformatf("tbl%0d valid", i), int'(note_valid), int'(tbl[i].valid));
            chk($sformatf("tbl%0d period", i), int'(period), tbl[i].per);
        end

        // DO lock timing
        do_reset();
        t0 = cyc + 1;
        fork
            wave(192, 4, 4'd15, 4'd0);
            begin
                at(t0 + 5);        chk("DO first crossing no strobe", int'(period_strobe), 0);
                at(t0 + 197);      chk("DO strobe 1", int'(period_strobe), 1);
                                   chk("DO period 1", int'(period), 192);
                                   chk("DO no note yet", int'(note), 0);
                at(t0 + 389);      chk("DO strobe 2", int'(period_strobe), 1);
                                   chk("DO note before classify", int'(note), 0);
                at(t0 + 390);      chk("DO note", int'(note), 8);
                                   chk("DO valid", int'(note_valid), 1);
            end
        join

        // note change SOL -> MI
        do_reset();
        t0 = cyc + 1;
        fork
            begin wave(128, 3, 4'd15, 4'd0); wave(150, 3, 4'd15, 4'd0); end
            begin
                at(t0 + 262);      chk("SOL locked", int'(note), 1);
                at(t0 + 390);      chk("SOL held", int'(note), 1);
                at(t0 + 540);      chk("first 150 drops note", int'(note), 0);
                                   chk("first 150 period", int'(period), 150);
                at(t0 + 690);      chk("MI locked", int'(note), 2);
            end
        join

        // silence timeout after RE lock
        do_reset();
        t0 = cyc + 1;
        fork
            begin wave(170, 3, 4'd15, 4'd0); drive(4'd0, 500); end
            begin
                at(t0 + 346);      chk("RE locked", int'(note), 4);
                at(t0 + 725);      chk("RE before timeout", int'(note_valid), 1);
                at(t0 + 726);      chk("timeout valid", int'(note_valid), 0);
                                   chk("timeout note", int'(note), 0);
            end
        join

        // largest strobed gap vs first gap that times out
        do_reset();
        t0 = cyc + 1;
        fork
            begin
                drive(4'd15, 100); drive(4'd0, 281);
                drive(4'd15, 100); drive(4'd0, 282);
                drive(4'd15, 10);  drive(4'd0, 20);
            end
            begin
                at(t0 + 386);      chk("gap 381 strobe", int'(period_strobe), 1);
                                   chk("gap 381 period", int'(period), 381);
                at(t0 + 768);      chk("gap 382 no strobe", int'(period_strobe), 0);
                                   chk("gap 382 period kept", int'(period), 381);
            end
        join

        // single-cycle spikes are filtered
        do_reset();
        nstb = 0;
        fork
            for (int g = 0; g < 5; g++) begin drive(4'd15, 1); drive(4'd0, 19); end
            repeat (100) begin @(negedge clk); if (period_strobe) nstb++; end
        join
        chk("glitch strobes", nstb, 0);
        t0 = cyc + 1;
        fork
            wave(192, 2, 4'd15, 4'd0);
            begin
                at(t0 + 5);        chk("after glitch first crossing", int'(period_strobe), 0);
                at(t0 + 197);      chk("after glitch period", int'(period), 192);
            end
        join

        // asynchronous reset while locked, then relock
        do_reset();
        wave(192, 3, 4'd15, 4'd0);
        chk("locked before async reset", int'(note), 8);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async note", int'(note), 0);
        chk("async valid", int'(note_valid), 0);
        chk("async period", int'(period), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        drive(4'd0, 5);
        t0 = cyc + 1;
        fork
            wave(192, 3, 4'd15, 4'd0);
            begin
                at(t0 + 5);        chk("relock first crossing", int'(period_strobe), 0);
                at(t0 + 389);      chk("relock not yet", int'(note_valid), 0);
                at(t0 + 390);      chk("relock valid", int'(note_valid), 1);
                                   chk("relock note", int'(note), 8);
            end
        join

        // random waveforms with sporadic spikes
        do_reset();
        repeat (30) begin
            per = plist[$urandom_range(0, 13)];
            n   = int'($urandom_range(1, 4));
            hi  = 4'($urandom_range(8, 15));
            lo  = 4'($urandom_range(0, 7));
            for (int k = 0; k < n; k++) begin
                for (int i = 0; i < per; i++) begin
                    v = (i < per / 2) ? hi : lo;
                    if ($urandom_range(0, 63) == 0) v = 4'($urandom_range(0, 15));
                    drive(v, 1);
                end
            end
        end
        drive(4'd0, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tone_detector.md
# tone_detector

Receive-side counterpart of the key-driven tone generator. It watches the 4-bit audio sample stream and measures the period between rising midpoint crossings. It classifies that period as one of the four note frequencies (DO 523 Hz, RE 587 Hz, MI 659 Hz, SOL 784 Hz) and reports the detected note as a one-hot code matching the key encoding. It sits on the sample bus next to the DAC output, is clocked by the system clock, and drives loopback self-test and note display.

## Interface
- CLK_HZ, 50_000_000, system clock frequency; per-note expected periods P_k = CLK_HZ / f_k (integer division, elaboration time).
- MID, 8, midpoint threshold on the 4-bit sample.
- CW, 20, period counter width; must satisfy 2^CW-1 >= TIMEOUT.
- TIMEOUT, 2*CLK_HZ/523, clk cycles without a crossing before declaring silence.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- sample  in  4  audio sample; may change on any clk edge (generator-derived clock).
- note  out  4  one-hot detected note: SOL=0001, MI=0010, RE=0100, DO=1000, none=0000.
- note_valid  out  1  high while note is locked.
- period  out  CW  last measured period in clk cycles.
- period_strobe  out  1  one-cycle pulse when period updates.

## Operation
- Input filter: s1<=sample, s2<=s1. filt<=s2 only when s1==s2. filt_prev holds the previous value of filt.
- Crossing: `xing` is registered high for one cycle when filt updates with filt_prev<MID and new filt>=MID.
- Counter cnt: cleared to 1 on the xing cycle, otherwise incremented; saturates at 2^CW-1.
- Period: on xing, period<=cnt (cycles since previous crossing), period_strobe<=1. Not issued on the first crossing after IDLE.
- Match window k: |period - P_k| <= P_k>>5. Windows are disjoint for the default notes. If several match, priority is DO>RE>MI>SOL.
- States:
  - IDLE: note=0, note_valid=0. On xing, go to MEASURE and start cnt.
  - MEASURE: on xing, compute the match.
    - Match equals the stored candidate: go to LOCKED, note<=candidate, note_valid<=1.
    - Match but differs from the candidate: candidate<=match, stay in MEASURE.
    - No match: candidate<=0, stay in MEASURE.
  - LOCKED: on xing, compute the match.
    - Same note: hold.
    - Different note: go to MEASURE, candidate<=new, note<=0, note_valid<=0.
    - No match: go to MEASURE, candidate<=0, note<=0, note_valid<=0.
  - Any state: cnt reaching TIMEOUT without a xing forces IDLE, note<=0, note_valid<=0, candidate<=0.
- A note therefore requires two consecutive matching periods, i.e. three crossings from IDLE.
- Simultaneous timeout and xing on the same cycle: xing wins.

## Timing
- Reset values: note=0, note_valid=0, period=0, period_strobe=0. Internally: s1=s2=filt=filt_prev=0, cnt=0, candidate=0, state IDLE.
- Sample edge to filt: 3 clk cycles when the new value holds for at least 2 cycles. xing follows 1 cycle later.
- xing to period/period_strobe: same edge, both registered, visible the cycle after xing.
- Period to note/note_valid: 1 cycle later (classification registered).
- A rst_n assertion mid-measurement clears everything immediately. The first crossing after release only re-arms MEASURE.

## Test plan
- Defaults: CLK_HZ=100_000, which gives P_DO=191 (window 186..196), P_RE=170, P_MI=151, P_SOL=127.
- Reset: hold rst_n low with sample toggling -> all outputs 0; after release with sample=0, note_valid stays 0.
- DO lock: square wave 15/0 with period 192 cycles -> period_strobe with period=192 from the 2nd crossing; note=1000 and note_valid=1 one cycle after the 3rd crossing.
- Note change: lock SOL (period 128, note=0001), then switch to period 150 -> note=0000 after the first 150 period; note=0010 after the second.
- Out of window: period 180 (between DO and RE) -> note_valid never asserts; period strobes still report 180.
- Silence timeout: lock RE (period 170), then hold sample=0 -> note=0000 and note_valid=0 exactly when cnt reaches 382 after the last crossing.
- Glitch and reset: 1-cycle spikes to 15 are ignored (no period_strobe). rst_n pulsed low while LOCKED -> outputs 0 asynchronously; relock needs 3 fresh crossings.
